fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction Fetch (IF) stage of the five-stage pipeline: owns the program counter, drives the instruction-memory address, and produces the current PC, fall-through PC, instruction word, 2-bit branch prediction and BTB-predicted target consumed by the IF/ID pipeline register. It holds an 8-entry branch history table (BHT) of 2-bit saturating counters and an 8-entry branch target buffer (BTB). Both tables are updated from the decode stage, where branches resolve, and mispredictions redirect the PC.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, opcode in inst[15:12] that freezes the PC.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- stall  input  1  hazard stall from decode; holds PC.
- instr_data  input  16  instruction word from memory; combinational read of instr_addr.
- update_en  input  1  decode resolved a branch this cycle.
- update_index  input  3  table index of the resolved branch (its PC[3:1]).
- actual_taken  input  1  resolved branch direction.
- actual_target  input  16  resolved branch target.
- mispredict  input  1  decode detected a misprediction.
- correct_PC  input  16  PC to fetch next on mispredict.
- instr_addr  output  16  equals PC_curr.
- PC_curr  output  16  address of the instruction being fetched.
- PC_next  output  16  PC_curr + 2, the fall-through address.
- PC_inst  output  16  equals instr_data.
- prediction  output  2  BHT counter at index PC_curr[3:1].
- predicted_target  output  16  BTB target at index PC_curr[3:1]. Reads 16'h0000 when the entry is invalid.

## Operation
- Index: idx = PC_curr[3:1]. All lookups are combinational and occur in the same cycle as the fetch.
- Predict taken: pred_taken = prediction[1] & btb_valid[idx].
- Next-PC priority, evaluated at each rising edge:
  1. mispredict loads correct_PC. This overrides stall and halt.
  2. stall holds the PC.
  3. If PC_inst[15:12] == HLT_OPCODE, the PC holds.
  4. pred_taken loads predicted_target.
  5. Otherwise the PC loads PC_next.
- Adder: PC_next = PC_curr + 16'd2, modulo 2^16. 16'hFFFE wraps to 16'h0000.
- BHT update when update_en is set:
  - actual_taken increments counter[update_index], saturating at 2'b11.
  - Otherwise it decrements the counter, saturating at 2'b00.
- BTB update when update_en & actual_taken: btb_target[update_index] <= actual_target and btb_valid <= 1.
  - A not-taken update leaves the BTB unchanged.
- update_en acts independently of stall and mispredict. Table writes still happen while stalled or halted.
- Reset (asynchronous, any time including mid-halt or mid-update):
  - PC <= RESET_PC.
  - All BHT counters <= 2'b00.
  - All btb_valid <= 0 and all btb_target <= 16'h0000.
- Outputs right after reset: PC_curr = RESET_PC, PC_next = RESET_PC + 2, prediction = 2'b00, predicted_target = 16'h0000.
  - PC_inst follows memory.

## Timing
- Fetch latency: 0 cycles. All outputs are combinational from the PC and tables, valid in the same cycle as PC_curr.
- PC update: 1 cycle. The new PC is visible after the next rising edge.
- Table writes take effect on the rising edge. A lookup at the same index in the same cycle sees the old value; the new value is visible the next cycle.
- mispredict together with stall: the redirect wins, and the PC = correct_PC next cycle.
- mispredict during halt: the redirect exits the halt.
- update_en together with a lookup of the same index: no bypass.
- Reset deassertion: the first fetch is at RESET_PC on the first rising edge after rst falls.

## Test plan
- Sequential fetch: reset, then 4 cycles of NOP (16'h0000) -> PC_curr = 0, 2, 4, 6, 8. prediction = 00 and predicted_target = 0 throughout.
- Training: update_en=1, update_index=3, actual_taken=1, actual_target=16'h0040 on 2 cycles.
  - Expected: counter[3] goes 00 -> 01 -> 10 and btb_valid[3] = 1.
  - Next fetch at PC 16'h0006 -> prediction = 10, next PC = 16'h0040.
- Saturation: 4 taken updates at idx 5 -> counter = 11. Then 5 not-taken updates -> counter = 00, and btb_valid[5] stays 1.
- Redirect priority: stall=1 together with mispredict=1, correct_PC=16'h0100 -> PC = 16'h0100 next cycle. With stall=1 alone, the PC holds for 3 cycles.
- Halt and wrap:
  - instr_data = 16'hF000 at PC 16'h0010 -> PC holds for 5 cycles. Then mispredict with correct_PC = 16'hFFFE -> PC = 16'hFFFE.
  - A NOP fetched at 16'hFFFE -> PC = 16'h0000.
- Async reset: assert rst mid-cycle after training idx 3 -> PC = RESET_PC immediately, without waiting for a clock edge. prediction = 00 and predicted_target = 0 at idx 3.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, next-PC selection, and an
// 8-entry branch predictor (2-bit BHT counters plus a BTB of targets).
// All lookups are combinational from the current PC; the tables are
// trained from decode, where branches resolve.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [15:0] instr_data,
    input  logic        update_en,
    input  logic [2:0]  update_index,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic        mispredict,
    input  logic [15:0] correct_PC,
    output logic [15:0] instr_addr,
    output logic [15:0] PC_curr,
    output logic [15:0] PC_next,
    output logic [15:0] PC_inst,
    output logic [1:0]  prediction,
    output logic [15:0] predicted_target
);

    logic [15:0] pc;
    logic [15:0] pc_target;
    logic [2:0]  idx;
    logic        pred_taken;
    logic        halted;

    logic [1:0]  bht        [8];
    logic [15:0] btb_target [8];
    logic [7:0]  btb_valid;

    assign idx        = pc[3:1];
    assign instr_addr = pc;
    assign PC_curr    = pc;
    assign PC_next    = pc + 16'd2;
    assign PC_inst    = instr_data;

    // Lookups read the pre-update table contents; writes land on the edge,
    // so there is deliberately no bypass from the update port.
    assign prediction       = bht[idx];
    assign predicted_target = btb_valid[idx] ? btb_target[idx] : 16'h0000;
    assign pred_taken       = prediction[1] & btb_valid[idx];
    assign halted           = (instr_data[15:12] == HLT_OPCODE);

    // Next-PC selection: redirect beats stall beats halt beats prediction.
    always_comb begin
        pc_target = pc;
        if (mispredict) begin
            pc_target = correct_PC;
        end else if (stall) begin
            pc_target = pc;
        end else if (halted) begin
            pc_target = pc;
        end else if (pred_taken) begin
            pc_target = predicted_target;
        end else begin
            pc_target = PC_next;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_target;
        end
    end

    // Predictor training; runs regardless of stall, halt or redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                bht[i]        <= 2'b00;
                btb_target[i] <= 16'h0000;
            end
            btb_valid <= 8'h00;
        end else if (update_en) begin
            if (actual_taken) begin
                if (bht[update_index] != 2'b11) begin
                    bht[update_index] <= bht[update_index] + 2'd1;
                end
                btb_target[update_index] <= actual_target;
                btb_valid[update_index]  <= 1'b1;
            end else if (bht[update_index] != 2'b00) begin
                bht[update_index] <= bht[update_index] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the PC and predictor tables.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [15:0] instr_data;
  logic        update_en;
  logic [2:0]  update_index;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        mispredict;
  logic [15:0] correct_PC;
  logic [15:0] instr_addr;
  logic [15:0] PC_curr;
  logic [15:0] PC_next;
  logic [15:0] PC_inst;
  logic [1:0]  prediction;
  logic [15:0] predicted_target;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [15:0] m_pc;
  int          m_cnt [8];
  bit          m_val [8];
  logic [15:0] m_tgt [8];

  fetch_stage #(.RESET_PC(RST_PC), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_data(instr_data),
    .update_en(update_en), .update_index(update_index),
    .actual_taken(actual_taken), .actual_target(actual_target),
    .mispredict(mispredict), .correct_PC(correct_PC),
    .instr_addr(instr_addr), .PC_curr(PC_curr), .PC_next(PC_next),
    .PC_inst(PC_inst), .prediction(prediction),
    .predicted_target(predicted_target)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_val[i] = 1'b0;
      m_tgt[i] = 16'h0000;
    end
  endtask

  // compare every output against the model for the current PC
  task automatic check_all();
    int k;
    k = int'(m_pc[3:1]);
    chk("instr_addr", instr_addr, m_pc);
    chk("pc_curr", PC_curr, m_pc);
    chk("pc_next", PC_next, 16'(m_pc + 16'd2));
    chk("pc_inst", PC_inst, instr_data);
    chk("prediction", {14'd0, prediction}, 16'(m_cnt[k]));
    chk("pred_target", predicted_target, m_val[k] ? m_tgt[k] : 16'h0000);
  endtask

  task automatic idle_inputs();
    stall = 0; instr_data = 16'h0000; update_en = 0; update_index = 0;
    actual_taken = 0; actual_target = 0; mispredict = 0; correct_PC = 0;
  endtask

  // one clock: compute the model's successor from current inputs, advance, check
  task automatic step();
    int          k;
    logic [15:0] npc;
    k = int'(m_pc[3:1]);
    if (mispredict)                    npc = correct_PC;
    else if (stall)                    npc = m_pc;
    else if (instr_data[15:12] == 4'hF) npc = m_pc;
    else if (m_cnt[k] >= 2 && m_val[k]) npc = m_tgt[k];
    else                               npc = m_pc + 16'd2;
    @(posedge clk);
    #1;
    m_pc = npc;
    if (update_en) begin
      if (actual_taken) begin
        m_cnt[update_index] = (m_cnt[update_index] == 3) ? 3 : m_cnt[update_index] + 1;
        m_val[update_index] = 1'b1;
        m_tgt[update_index] = actual_target;
      end else begin
        m_cnt[update_index] = (m_cnt[update_index] == 0) ? 0 : m_cnt[update_index] - 1;
      end
    end
    check_all();
  endtask

  task automatic redirect(input logic [15:0] target);
    idle_inputs();
    mispredict = 1; correct_PC = target;
    step();
    idle_inputs();
  endtask

  initial begin
    // reset
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    check_all();
    rst = 0;
    #2;
    chk("reset_pc", PC_curr, RST_PC);
    chk("reset_pred", {14'd0, prediction}, 16'h0000);

    // sequential fetch of NOPs
    for (int i = 0; i < 4; i++) step();
    chk("seq_pc", PC_curr, 16'h0008);

    // training idx 3 toward taken, target 0x0040
    update_en = 1; update_index = 3; actual_taken = 1; actual_target = 16'h0040;
    step();
    step();
    idle_inputs();
    redirect(16'h0006);
    chk("train_pred", {14'd0, prediction}, 16'h0002);
    chk("train_tgt", predicted_target, 16'h0040);
    step();
    chk("train_jump", PC_curr, 16'h0040);

    // saturation at idx 5, watched from a stalled fetch at 0x000A
    redirect(16'h000A);
    stall = 1; update_en = 1; update_index = 5; actual_target = 16'h0222;
    actual_taken = 1;
    for (int i = 0; i < 4; i++) step();
    chk("sat_hi", {14'd0, prediction}, 16'h0003);
    actual_taken = 0;
    for (int i = 0; i < 5; i++) step();
    chk("sat_lo", {14'd0, prediction}, 16'h0000);
    chk("sat_btb", predicted_target, 16'h0222);
    idle_inputs();

    // redirect beats stall; stall alone holds
    stall = 1; mispredict = 1; correct_PC = 16'h0100;
    step();
    chk("redir_stall", PC_curr, 16'h0100);
    idle_inputs();
    stall = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_hold", PC_curr, 16'h0100);
    idle_inputs();

    // halt, redirect out of halt, and adder wrap
    redirect(16'h0010);
    instr_data = 16'hF000;
    for (int i = 0; i < 5; i++) step();
    chk("halt_hold", PC_curr, 16'h0010);
    mispredict = 1; correct_PC = 16'hFFFE;
    step();
    chk("halt_exit", PC_curr, 16'hFFFE);
    idle_inputs();
    chk("wrap_next", PC_next, 16'h0000);
    step();
    chk("wrap_pc", PC_curr, 16'h0000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 3) == 0);
      mispredict   = ($urandom_range(0, 7) == 0);
      correct_PC   = 16'($urandom_range(0, 15) * 2);
      instr_data   = 16'($urandom);
      if (instr_data[15:12] == 4'hF && $urandom_range(0, 3) != 0) instr_data[15] = 1'b0;
      update_en    = ($urandom_range(0, 1) == 1);
      update_index = 3'($urandom_range(0, 7));
      actual_taken = ($urandom_range(0, 2) != 0);
      actual_target = 16'($urandom_range(0, 15) * 2);
      step();
    end
    idle_inputs();

    // asynchronous reset mid-cycle after training idx 3
    redirect(16'h0020);
    update_en = 1; update_index = 3; actual_taken = 1; actual_target = 16'h0040;
    stall = 1;
    step();
    step();
    idle_inputs();
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("async_pc", PC_curr, RST_PC);
    check_all();
    #3;
    rst = 0;
    @(posedge clk);
    #1;
    chk("post_rst_pc", PC_curr, 16'h0002);
    m_pc = 16'h0002;
    redirect(16'h0006);
    chk("rst_pred3", {14'd0, prediction}, 16'h0000);
    chk("rst_tgt3", predicted_target, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // safety limit
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
